// File: rtl/wishbone_uart_slave_if.sv
// Wishbone bus bundle between the master and the UART slave.
interface wishbone_uart_slave_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [7:0]  adr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, dat_o
    );
endinterface

// File: rtl/wishbone_uart_slave.sv
// Wishbone UART peripheral: CTRL/STATUS/RXDATA/TXDATA registers, TX FIFO into
// an 8N1 serialiser, 8N1 deserialiser into an RX FIFO.
//
// state   | meaning (shared by the TX and RX machines)
// S_IDLE  | line idle, waiting for a byte (TX) or a falling edge (RX)
// S_START | start bit in progress
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit in progress
module wishbone_uart_slave #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    wishbone_uart_slave_if.slave bus,
    output logic                 uart_tx_o,
    input  logic                 uart_rx_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    logic        tx_en, rx_en;
    logic [15:0] divisor, div_eff;
    logic        rx_overflow, frame_err;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic          tx_empty, tx_full, rx_empty, rx_full;
    logic          tx_push, tx_pop, rx_push, rx_pop;

    uart_state_t tx_state, rx_state;
    logic [15:0] tx_tmr, tx_div, rx_tmr, rx_div;
    logic [2:0]  tx_bit, rx_bit;
    logic [7:0]  tx_shift, rx_shift;
    logic [1:0]  rx_sync;
    logic        rx_prev, rx_push_q, rx_ferr_q;

    logic        req, wr_stat;
    logic [1:0]  reg_idx;
    logic [3:0]  rx_level;
    logic [31:0] rd_data;

    // Address bits outside [3:2] and CTRL byte lane 1 carry nothing.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.adr_i[7:4], bus.adr_i[1:0], bus.dat_i[15:8]};

    assign req      = bus.cyc_i & bus.stb_i & ~bus.ack_o;
    assign reg_idx  = bus.adr_i[3:2];
    assign wr_stat  = req & bus.we_i & (reg_idx == 2'd1);
    assign tx_push  = req & bus.we_i & (reg_idx == 2'd3) & bus.sel_i[0] & ~tx_full;
    assign rx_pop   = req & ~bus.we_i & (reg_idx == 2'd2) & ~rx_empty;
    assign rx_push  = rx_push_q & ~rx_full;
    assign div_eff  = (divisor < 16'd4) ? 16'd4 : divisor;
    assign rx_level = (32'(rx_cnt) > 32'd15) ? 4'd15 : 4'(rx_cnt);

    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = (tx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);

    // TX pops when a new frame starts, either from idle or straight out of a stop bit.
    assign tx_pop = tx_en & ~tx_empty &
                    ((tx_state == S_IDLE) | ((tx_state == S_STOP) & (tx_tmr == '0)));

    // Read data mux for the addressed register.
    always_comb begin
        rd_data = '0;
        case (reg_idx)
            2'd0: rd_data = {divisor, 14'd0, rx_en, tx_en};
            2'd1: rd_data = {20'd0, rx_level, 2'b00, frame_err, rx_overflow,
                             rx_full, rx_empty, tx_full, tx_empty};
            2'd2: if (!rx_empty) rd_data = {24'd0, rx_mem[rx_rd]};
            default: rd_data = '0;
        endcase
    end

    // Bus handshake, read data capture and CTRL writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.ack_o <= 1'b0;
            bus.dat_o <= '0;
            tx_en     <= 1'b0;
            rx_en     <= 1'b0;
            divisor   <= DEFAULT_DIV;
        end else begin
            bus.ack_o <= req;
            bus.dat_o <= (req & ~bus.we_i) ? rd_data : '0;
            if (req & bus.we_i & (reg_idx == 2'd0)) begin
                if (bus.sel_i[0]) {rx_en, tx_en} <= bus.dat_i[1:0];
                if (bus.sel_i[2]) divisor[7:0]   <= bus.dat_i[23:16];
                if (bus.sel_i[3]) divisor[15:8]  <= bus.dat_i[31:24];
            end
        end
    end

    // Sticky error flags; a new event in the same cycle as a clear wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_overflow <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (wr_stat & bus.dat_i[4]) rx_overflow <= 1'b0;
            if (rx_push_q & rx_full)    rx_overflow <= 1'b1;
            if (wr_stat & bus.dat_i[5]) frame_err   <= 1'b0;
            if (rx_ferr_q)              frame_err   <= 1'b1;
        end
    end

    // FIFO storage, no reset needed since occupancy is tracked by the counters.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wr] <= bus.dat_i[7:0];
        if (rx_push) rx_mem[rx_wr] <= rx_shift;
    end

    // FIFO pointers and occupancy counts; push and pop together leave the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

    // TX serialiser; divisor is latched per frame so a CTRL write never stretches a frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state  <= S_IDLE;
            tx_tmr    <= '0;
            tx_div    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            uart_tx_o <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE, S_STOP: begin
                    if (tx_state == S_STOP && tx_tmr != '0) begin
                        tx_tmr <= tx_tmr - 16'd1;
                    end else if (tx_pop) begin
                        tx_shift  <= tx_mem[tx_rd];
                        tx_div    <= div_eff;
                        tx_tmr    <= div_eff - 16'd1;
                        uart_tx_o <= 1'b0;
                        tx_state  <= S_START;
                    end else begin
                        tx_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (tx_tmr == '0) begin
                        tx_tmr    <= tx_div - 16'd1;
                        tx_bit    <= '0;
                        uart_tx_o <= tx_shift[0];
                        tx_state  <= S_DATA;
                    end else begin
                        tx_tmr <= tx_tmr - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_tmr == '0) begin
                        tx_tmr <= tx_div - 16'd1;
                        if (tx_bit == 3'd7) begin
                            uart_tx_o <= 1'b1;
                            tx_state  <= S_STOP;
                        end else begin
                            tx_bit    <= tx_bit + 3'd1;
                            tx_shift  <= {1'b0, tx_shift[7:1]};
                            uart_tx_o <= tx_shift[1];
                        end
                    end else begin
                        tx_tmr <= tx_tmr - 16'd1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_sync <= 2'b11;
        else         rx_sync <= {rx_sync[0], uart_rx_i};
    end

    // RX deserialiser; the first wait is shortened by the synchroniser and edge-detect
    // latency so every sample lands on the bit centre.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_state  <= S_IDLE;
            rx_tmr    <= '0;
            rx_div    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_prev   <= 1'b1;
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            rx_prev   <= rx_sync[1];
            rx_push_q <= 1'b0;
            rx_ferr_q <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_en & rx_prev & ~rx_sync[1]) begin
                        rx_div   <= div_eff;
                        rx_tmr   <= (div_eff >> 1) - 16'd2;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_tmr == '0) begin
                        if (rx_sync[1]) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_tmr   <= rx_div - 16'd1;
                            rx_bit   <= '0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_tmr <= rx_tmr - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_tmr == '0) begin
                        rx_shift <= {rx_sync[1], rx_shift[7:1]};
                        rx_tmr   <= rx_div - 16'd1;
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                    end else begin
                        rx_tmr <= rx_tmr - 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_tmr == '0) begin
                        rx_push_q <= rx_sync[1];
                        rx_ferr_q <= ~rx_sync[1];
                        rx_state  <= S_IDLE;
                    end else begin
                        rx_tmr <= rx_tmr - 16'd1;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wishbone_uart_slave.sv
// Scoreboard bench for wishbone_uart_slave: bus reads and serial TX frames are
// predicted by a queue-based model and checked by independent monitors.
module tb_wishbone_uart_slave;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic rx_line = 1'b1;
    logic tx_line;

    always #5 clk = ~clk;

    wishbone_uart_slave_if bus_if();

    wishbone_uart_slave #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus_if),
        .uart_tx_o(tx_line),
        .uart_rx_i(rx_line)
    );

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t         sb_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    longint      cyc_cnt = 0;
    logic [31:0] m_ctrl;
    logic [7:0]  m_txq[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  m_rxq[$];
    bit          m_ovf = 0;
    bit          m_ferr = 0;
    longint      tx_starts[$];
    bit          mon_ignore = 0;
    bit          prev_ack = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int eff_div();
        int d = int'(m_ctrl[31:16]);
        return (d < 4) ? 4 : d;
    endfunction

    function automatic logic [31:0] m_status();
        int c = m_rxq.size();
        logic [31:0] s = '0;
        s[0] = (m_txq.size() == 0);
        s[1] = (m_txq.size() == DEPTH);
        s[2] = (c == 0);
        s[3] = (c == DEPTH);
        s[4] = m_ovf;
        s[5] = m_ferr;
        s[11:8] = (c > 15) ? 4'd15 : 4'(c);
        return s;
    endfunction

    function automatic void m_flush();
        if (m_ctrl[0]) while (m_txq.size() != 0) exp_tx.push_back(m_txq.pop_front());
    endfunction

    function automatic void m_reset();
        m_ctrl = {16'd434, 16'd0};
        m_txq.delete();
        exp_tx.delete();
        m_rxq.delete();
        m_ovf = 0;
        m_ferr = 0;
    endfunction

    task automatic wb(input bit we, input logic [7:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit chk, input logic [31:0] exp,
                      input string name);
        int n = 0;
        sb_t e;
        e.chk = chk;
        e.exp = exp;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus_if.cyc_i = 1'b1;
        bus_if.stb_i = 1'b1;
        bus_if.we_i  = we;
        bus_if.adr_i = adr;
        bus_if.dat_i = dat;
        bus_if.sel_i = sel;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus_if.ack_o !== 1'b1 && n < 8);
        check({name, "_ack_latency"}, 32'(n), 32'd1);
        bus_if.cyc_i = 1'b0;
        bus_if.stb_i = 1'b0;
        bus_if.we_i  = 1'b0;
    endtask

    task automatic ctrl_write(input logic [31:0] dat, input logic [3:0] sel);
        for (int i = 0; i < 4; i++) if (sel[i]) m_ctrl[8*i +: 8] = dat[8*i +: 8];
        m_ctrl &= 32'hFFFF_0003;
        m_flush();
        wb(1'b1, 8'h00, dat, sel, 1'b0, '0, "ctrl_wr");
    endtask

    task automatic tx_write(input logic [7:0] b, input logic [3:0] sel);
        if (sel[0] && m_txq.size() < DEPTH) m_txq.push_back(b);
        m_flush();
        wb(1'b1, 8'h0C, {24'hDEADBE, b}, sel, 1'b0, '0, "txdata_wr");
    endtask

    task automatic status_clear(input logic [31:0] dat);
        if (dat[4]) m_ovf = 0;
        if (dat[5]) m_ferr = 0;
        wb(1'b1, 8'h04, dat, 4'hF, 1'b0, '0, "status_wr");
    endtask

    task automatic read_status(input string name);
        wb(1'b0, 8'h04, '0, 4'hF, 1'b1, m_status(), name);
    endtask

    task automatic read_ctrl(input string name);
        wb(1'b0, 8'h00, '0, 4'hF, 1'b1, m_ctrl, name);
    endtask

    task automatic read_rx(input string name);
        logic [31:0] e = '0;
        if (m_rxq.size() != 0) e = {24'd0, m_rxq.pop_front()};
        wb(1'b0, 8'h08, '0, 4'hF, 1'b1, e, name);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
        int d = eff_div();
        @(posedge clk); #1 rx_line = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (d) @(posedge clk);
            #1 rx_line = b[i];
        end
        repeat (d) @(posedge clk);
        #1 rx_line = stop_ok;
        repeat (d) @(posedge clk);
        #1 rx_line = 1'b1;
        repeat (2 * d) @(posedge clk);
        if (!stop_ok)                  m_ferr = 1;
        else if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
        else                           m_ovf = 1;
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (exp_tx.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("tx_drain", 32'(exp_tx.size()), 32'd0);
        repeat (2 * eff_div()) @(posedge clk);
    endtask

    // Bus monitor: every ack pops one scoreboard entry; read data compared in the ack cycle.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (bus_if.ack_o === 1'b1) begin
                if (prev_ack) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL ack_width: ack high 2 cycles, required 1");
                end
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: ack with no outstanding access");
                end else begin
                    e = sb_q.pop_front();
                    if (e.chk) check(e.name, bus_if.dat_o, e.exp);
                end
            end
            prev_ack = (bus_if.ack_o === 1'b1);
        end
    end

    // Serial monitor: decodes 8N1 frames on uart_tx_o at the bit centres.
    initial begin
        longint     t0;
        int         d;
        logic [7:0] b;
        logic       st, sp;
        forever begin
            @(negedge clk);
            if (rst_n && tx_line === 1'b0) begin
                t0 = cyc_cnt;
                d = eff_div();
                repeat (d / 2) @(negedge clk);
                st = tx_line;
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx_line;
                end
                repeat (d) @(negedge clk);
                sp = tx_line;
                if (!mon_ignore) begin
                    tx_starts.push_back(t0);
                    check("tx_start_bit", 32'(st), 32'd0);
                    check("tx_stop_bit", 32'(sp), 32'd1);
                    if (exp_tx.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL tx_frame: got byte 0x%02h, required no frame", b);
                    end else begin
                        check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int nrx;
        bus_if.cyc_i = 1'b0;
        bus_if.stb_i = 1'b0;
        bus_if.we_i  = 1'b0;
        bus_if.adr_i = '0;
        bus_if.dat_i = '0;
        bus_if.sel_i = '0;
        m_reset();

        #1 rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_tx_line", 32'(tx_line), 32'd1);
        check("reset_ack", 32'(bus_if.ack_o), 32'd0);
        check("reset_dat", bus_if.dat_o, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        wb(1'b0, 8'h04, '0, 4'hF, 1'b1, 32'h0000_0005, "reset_status");
        read_ctrl("reset_ctrl");
        read_rx("rxdata_empty");
        wb(1'b0, 8'h0C, '0, 4'hF, 1'b1, 32'h0, "txdata_read");

        // Basic transmit, div 4
        ctrl_write(32'h0004_0001, 4'hF);
        tx_write(8'hA5, 4'h1);
        wait_tx_done();
        read_status("tx_done_status");
        for (int k = 0; k < 3; k++) begin
            tx_write(8'($urandom), 4'h1);
            wait_tx_done();
        end

        // Byte-lane write sets divisor to 2, which runs at the clamped 4
        ctrl_write(32'hAB02_0000, 4'b0100);
        read_ctrl("ctrl_lane_clamp");
        tx_write(8'($urandom), 4'h1);
        wait_tx_done();

        // Receive
        ctrl_write(32'h0004_0002, 4'hF);
        rx_frame(8'h3C, 1'b1);
        read_status("rx_one_status");
        read_rx("rx_3c");
        read_rx("rx_empty_read");
        read_status("rx_drained_status");
        nrx = $urandom_range(2, 5);
        for (int k = 0; k < nrx; k++) rx_frame(8'($urandom), 1'b1);
        read_status("rx_multi_status");
        for (int k = 0; k < nrx; k++) read_rx("rx_multi_data");

        // TX FIFO fill with TX disabled, then a back-to-back burst
        ctrl_write(32'h0004_0000, 4'hF);
        tx_write(8'h77, 4'b1110);
        read_status("tx_nosel_status");
        for (int k = 0; k < DEPTH; k++) tx_write(8'($urandom), 4'h1);
        read_status("tx_full_status");
        tx_write(8'($urandom), 4'h1);
        read_status("tx_drop_status");
        tx_starts.delete();
        ctrl_write(32'h0004_0001, 4'hF);
        wait_tx_done();
        check("burst_frames", 32'(tx_starts.size()), 32'd8);
        for (int k = 1; k < tx_starts.size(); k++)
            check("burst_gap", 32'(tx_starts[k] - tx_starts[k-1]), 32'd40);
        read_status("burst_done_status");

        // RX overflow
        ctrl_write(32'h0004_0002, 4'hF);
        for (int k = 0; k < DEPTH + 1; k++) rx_frame(8'($urandom), 1'b1);
        read_status("rx_overflow_status");
        status_clear(32'h0000_0010);
        read_status("rx_ovf_cleared_status");
        for (int k = 0; k < DEPTH; k++) read_rx("rx_full_data");
        read_status("rx_emptied_status");

        // Framing error, then a one-cycle glitch that must be ignored
        v = 8'($urandom);
        rx_frame(v, 1'b0);
        read_status("frame_err_status");
        status_clear(32'h0000_0020);
        read_status("frame_err_cleared");
        @(posedge clk); #1 rx_line = 1'b0;
        @(posedge clk); #1 rx_line = 1'b1;
        repeat (48) @(posedge clk);
        read_status("glitch_status");

        // Reset in the middle of a TX frame
        ctrl_write(32'h0004_0001, 4'hF);
        mon_ignore = 1;
        tx_write(8'h5A, 4'h1);
        tx_write(8'hC3, 4'h1);
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midframe_reset_tx", 32'(tx_line), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        m_reset();
        read_status("post_reset_status");
        read_ctrl("post_reset_ctrl");
        repeat (60) @(posedge clk);
        #1;
        check("post_reset_idle_line", 32'(tx_line), 32'd1);

        repeat (4) @(posedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
